// File: rtl/ucie_ctl_sb_pkg.sv
// ucie_ctl_sb_pkg: shared constants, TX state encoding, code layout and phase-word builders
// Contents: opcodes, msgcode/subcode constants, srcid/dstid, tx_state_t, sb_code_t,
//           ph0_word()/ph1_word() helpers used by the sideband TX scheduler.
package ucie_ctl_sb_pkg;

    localparam logic [4:0] OP_NODATA = 5'b10010;
    localparam logic [4:0] OP_DATA   = 5'b11011;

    localparam logic [7:0] MSG_WDATA = 8'h01;
    localparam logic [7:0] MSG_CLS1  = 8'h03;
    localparam logic [7:0] MSG_CLS2  = 8'h04;
    localparam logic [7:0] MSG_CLS3  = 8'h09;

    localparam logic [7:0] SUB_00 = 8'h00;
    localparam logic [7:0] SUB_01 = 8'h01;
    localparam logic [7:0] SUB_09 = 8'h09;

    localparam logic [2:0] SRCID = 3'b001;
    localparam logic [2:0] DSTID = 3'b101;

    typedef enum logic [2:0] {ST_IDLE, ST_PH0, ST_PH1, ST_PH2, ST_PH3} tx_state_t;

    typedef struct packed {
        logic       no_data;
        logic [1:0] cls;
        logic [1:0] sub;
    } sb_code_t;

    function automatic logic [31:0] ph0_word(input logic with_data, input logic [7:0] msgcode);
        return {SRCID, 7'd0, msgcode, 9'd0, with_data ? OP_DATA : OP_NODATA};
    endfunction

    function automatic logic [31:0] ph1_word(input logic [7:0] subcode, input logic cp, input logic dp);
        return {dp, cp, 3'd0, DSTID, 16'd0, subcode};
    endfunction

endpackage

// File: rtl/ucie_ctl_sb_tx_sched_if.sv
// ucie_ctl_sb_tx_sched_if: requester and serializer handshake bundle of the sideband TX scheduler
// master: requesters/serializer (drive vld, code, data, count_done; receive ack, err, phase)
// slave : the scheduler
interface ucie_ctl_sb_tx_sched_if;

    logic [1:0]  i_req_vld;
    logic [4:0]  i_req_code_0;
    logic [4:0]  i_req_code_1;
    logic [31:0] i_req_data_0;
    logic [31:0] i_req_data_1;
    logic        i_count_done;
    logic [1:0]  o_req_ack;
    logic        o_req_err;
    logic        o_phase_vld;
    logic [31:0] o_phase_data;

    modport master (
        output i_req_vld, i_req_code_0, i_req_code_1, i_req_data_0, i_req_data_1, i_count_done,
        input  o_req_ack, o_req_err, o_phase_vld, o_phase_data
    );

    modport slave (
        input  i_req_vld, i_req_code_0, i_req_code_1, i_req_data_0, i_req_data_1, i_count_done,
        output o_req_ack, o_req_err, o_phase_vld, o_phase_data
    );

endinterface

// File: rtl/ucie_ctl_sb_tx_encode.sv
// ucie_ctl_sb_tx_encode: combinational 5-bit message code to {msgcode, subcode, with_data, valid}
// Ports: i_code (5-bit RX-decode style code); o_msgcode, o_subcode, o_with_data, o_valid.
module ucie_ctl_sb_tx_encode
    import ucie_ctl_sb_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [7:0] o_msgcode,
    output logic [7:0] o_subcode,
    output logic       o_with_data,
    output logic       o_valid
);

    sb_code_t c;

    assign c = i_code;
    assign o_with_data = !c.no_data;
    // Classes 01/10 only define the odd subs; class 11 defines all but sub 11; class 00 is unused.
    assign o_valid = !c.no_data || (c.cls == 2'b11 ? c.sub != 2'b11 : c.cls != 2'b00 && c.sub[0]);
    assign o_msgcode = !c.no_data ? MSG_WDATA : c.cls == 2'b11 ? MSG_CLS3 : c.cls == 2'b10 ? MSG_CLS2 : MSG_CLS1;
    assign o_subcode = !c.no_data ? SUB_00 : c.cls == 2'b11 ? {6'd0, c.sub} : c.sub[1] ? SUB_09 : SUB_01;

endmodule

// File: rtl/ucie_ctl_sb_tx_sched.sv
// ucie_ctl_sb_tx_sched: round-robin sideband TX scheduler with credit gating and 32-bit phase output
// Ports: i_clk, i_rst (async, active high), i_cfg_crd (credit return pulse),
//        o_busy (not IDLE), o_crd_avail (credit > 0), bus (slave modport: requests, ack/err, phases).
// Optional: define UCIE_CTL_SB_TX_PARITY_EN to fill phase 1 cp/dp parity bits.
module ucie_ctl_sb_tx_sched
    import ucie_ctl_sb_pkg::*;
#(
    parameter int CRD_INIT = 1,
    parameter int CRD_MAX  = 3,
    parameter int CRD_W    = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cfg_crd,
    output logic                   o_busy,
    output logic                   o_crd_avail,
    ucie_ctl_sb_tx_sched_if.slave  bus
);

    tx_state_t        state;
    logic [CRD_W-1:0] crd;
    logic             ptr;
    logic             sel, grant, inc, dec;
    logic [7:0]       msgcode, subcode, msg_q, sub_q;
    logic             with_data, valid, wd_q;
    logic [31:0]      data_q, ph1_w, phase_q;
    logic [1:0]       ack_q;
    logic             err_q, pvld_q;

    // ptr names the requester favoured on a tie.
    assign sel = &bus.i_req_vld ? ptr : bus.i_req_vld[1];
    // The ack cycle is skipped so a requester still holding vld during its ack is not served twice.
    assign grant = state == ST_IDLE && |bus.i_req_vld && crd != '0 && ack_q == 2'b00;
    assign dec = grant && valid;
    assign inc = i_cfg_crd && crd != CRD_W'(CRD_MAX);

    ucie_ctl_sb_tx_encode u_enc (
        .i_code      (sel ? bus.i_req_code_1 : bus.i_req_code_0),
        .o_msgcode   (msgcode),
        .o_subcode   (subcode),
        .o_with_data (with_data),
        .o_valid     (valid)
    );

`ifdef UCIE_CTL_SB_TX_PARITY_EN
    assign ph1_w = ph1_word(sub_q, (^ph0_word(wd_q, msg_q)) ^ (^ph1_word(sub_q, 1'b0, 1'b0)), wd_q & (^data_q));
`else
    assign ph1_w = ph1_word(sub_q, 1'b0, 1'b0);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            crd     <= CRD_W'(CRD_INIT);
            ptr     <= 1'b0;
            msg_q   <= '0;
            sub_q   <= '0;
            wd_q    <= 1'b0;
            data_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            pvld_q  <= 1'b0;
            phase_q <= '0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            // A return and a spend in the same cycle cancel, even at saturation.
            crd <= inc && !dec ? crd + CRD_W'(1) : dec && !i_cfg_crd ? crd - CRD_W'(1) : crd;
            case (state)
                ST_IDLE: if (grant) begin
                    ack_q <= sel ? 2'b10 : 2'b01;
                    ptr   <= !sel;
                    if (valid) begin
                        state   <= ST_PH0;
                        msg_q   <= msgcode;
                        sub_q   <= subcode;
                        wd_q    <= with_data;
                        data_q  <= sel ? bus.i_req_data_1 : bus.i_req_data_0;
                        pvld_q  <= 1'b1;
                        phase_q <= ph0_word(with_data, msgcode);
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                ST_PH0: if (bus.i_count_done) begin
                    state   <= ST_PH1;
                    phase_q <= ph1_w;
                end
                ST_PH1: if (bus.i_count_done) begin
                    state   <= wd_q ? ST_PH2 : ST_IDLE;
                    pvld_q  <= wd_q;
                    phase_q <= wd_q ? data_q : '0;
                end
                ST_PH2: if (bus.i_count_done) begin
                    state   <= ST_PH3;
                    phase_q <= '0;
                end
                ST_PH3: if (bus.i_count_done) begin
                    state  <= ST_IDLE;
                    pvld_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_req_ack    = ack_q;
    assign bus.o_req_err    = err_q;
    assign bus.o_phase_vld  = pvld_q;
    assign bus.o_phase_data = phase_q;
    assign o_busy           = state != ST_IDLE;
    assign o_crd_avail      = |crd;

endmodule

// File: tb/tb_ucie_ctl_sb_tx_sched.sv
// tb_ucie_ctl_sb_tx_sched: directed and randomized self-checking bench for ucie_ctl_sb_tx_sched
module tb_ucie_ctl_sb_tx_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg = 1'b0;
    logic busy, crd_avail;
    int   checks = 0;
    int   failures = 0;

    int               crd_m;
    logic             pref_m;
    logic [1:0]       pend;
    logic [4:0]       rc [2];
    logic [31:0]      rd [2];
    logic             exp_r, got;
    int               n;
    logic [3:0][31:0] w;
    logic [31:0]      dval;

    ucie_ctl_sb_tx_sched_if bus();

    ucie_ctl_sb_tx_sched #(.CRD_INIT(1), .CRD_MAX(3), .CRD_W(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_crd   (cfg),
        .o_busy      (busy),
        .o_crd_avail (crd_avail),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Message model: returns phase count (0 = invalid code) and the expected phase words.
    function automatic int model(input logic [4:0] code, input logic [31:0] d, output logic [3:0][31:0] wo);
        int cls, sub, msg, sc, cnt;
        cls = int'(code[3:2]);
        sub = int'(code[1:0]);
        wo = '0;
        if (!code[4]) begin
            msg = 1; sc = 0; cnt = 4;
        end else if ((cls == 1 || cls == 2) && sub % 2 == 1) begin
            msg = cls + 2; sc = (sub == 1) ? 1 : 9; cnt = 2;
        end else if (cls == 3 && sub != 3) begin
            msg = 9; sc = sub; cnt = 2;
        end else begin
            return 0;
        end
        wo[0] = (code[4] ? 32'h12 : 32'h1B) + 32'(msg) * 32'h4000 + 32'h2000_0000;
        wo[1] = 32'(sc) + 32'h0500_0000;
`ifdef UCIE_CTL_SB_TX_PARITY_EN
        if (($countones(wo[0]) + $countones(wo[1][29:0])) % 2 == 1) wo[1] = wo[1] + 32'h4000_0000;
        if (cnt == 4 && $countones(d) % 2 == 1) wo[1] = wo[1] + 32'h8000_0000;
`endif
        if (cnt == 4) wo[2] = d;
        return cnt;
    endfunction

    // Walks the phases of an accepted message starting in its ack cycle.
    task automatic walk(input int cnt, input logic [3:0][31:0] wv, input bit rnd);
        for (int i = 0; i < cnt; i++) begin
            chk("phase_vld", 32'(bus.o_phase_vld), 32'd1);
            chk($sformatf("phase%0d", i), bus.o_phase_data, wv[i]);
            if (rnd) begin
                for (int h = $urandom_range(0, 2); h > 0; h--) begin
                    bus.i_count_done = 1'b0;
                    tick();
                    chk("phase_hold", bus.o_phase_data, wv[i]);
                end
            end
            bus.i_count_done = 1'b1;
            cfg = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (cfg) crd_m = crd_m < 3 ? crd_m + 1 : 3;
            cfg = 1'b0;
            bus.i_count_done = !rnd;
        end
        chk("idle_vld", 32'(bus.o_phase_vld), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bus.i_req_vld = '0;
        bus.i_req_code_0 = '0;
        bus.i_req_code_1 = '0;
        bus.i_req_data_0 = '0;
        bus.i_req_data_1 = '0;
        bus.i_count_done = 1'b0;
        #12 rst = 1'b0;

        // Reset state
        chk("rst_ack", 32'(bus.o_req_ack), 32'd0);
        chk("rst_err", 32'(bus.o_req_err), 32'd0);
        chk("rst_vld", 32'(bus.o_phase_vld), 32'd0);
        chk("rst_data", bus.o_phase_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_crd", 32'(crd_avail), 32'd1);
        crd_m = 1;
        pref_m = 1'b0;

        // Req0 without data, count_done held high
        bus.i_req_vld = 2'b01;
        bus.i_req_code_0 = 5'b10101;
        bus.i_count_done = 1'b1;
        tick();
        chk("tp1_ack", 32'(bus.o_req_ack), 32'd1);
        chk("tp1_ph0", bus.o_phase_data, 32'h2000_C012);
        chk("tp1_crd", 32'(crd_avail), 32'd0);
        bus.i_req_vld = 2'b00;
        n = model(5'b10101, 32'h0, w);
        walk(n, w, 1'b0);
        crd_m = 0;
        pref_m = 1'b1;

        // Req1 with data while out of credit
        bus.i_req_vld = 2'b10;
        bus.i_req_code_1 = 5'b00000;
        bus.i_req_data_1 = 32'h0000_0001;
        tick();
        chk("nocrd_ack0", 32'(bus.o_req_ack), 32'd0);
        tick();
        chk("nocrd_ack1", 32'(bus.o_req_ack), 32'd0);
        cfg = 1'b1;
        tick();
        cfg = 1'b0;
        chk("crd_ret_ack", 32'(bus.o_req_ack), 32'd0);
        tick();
        chk("crd_ret_grant", 32'(bus.o_req_ack), 32'd2);
        bus.i_req_vld = 2'b00;
        chk("tp2_ph0", bus.o_phase_data, 32'h2000_401B);
        tick();
`ifdef UCIE_CTL_SB_TX_PARITY_EN
        chk("tp2_ph1", bus.o_phase_data, 32'h8500_0000);
`else
        chk("tp2_ph1", bus.o_phase_data, 32'h0500_0000);
`endif
        tick();
        chk("tp2_ph2", bus.o_phase_data, 32'h0000_0001);
        tick();
        chk("tp2_ph3", bus.o_phase_data, 32'h0000_0000);
        chk("tp2_ph3_vld", 32'(bus.o_phase_vld), 32'd1);
        tick();
        chk("tp2_idle", 32'(bus.o_phase_vld), 32'd0);
        crd_m = 0;
        pref_m = 1'b0;

        // Saturate credit at 3, then alternate grants until credit runs out
        for (int k = 0; k < 4; k++) begin
            cfg = 1'b1;
            tick();
        end
        cfg = 1'b0;
        crd_m = 3;
        bus.i_req_vld = 2'b11;
        bus.i_req_code_0 = 5'b10101;
        bus.i_req_code_1 = 5'b11100;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("alt_ack%0d", k), 32'(bus.o_req_ack), (k % 2 == 0) ? 32'd1 : 32'd2);
            n = model(k % 2 == 0 ? 5'b10101 : 5'b11100, 32'h0, w);
            walk(n, w, 1'b0);
        end
        tick();
        chk("sat_stall0", 32'(bus.o_req_ack), 32'd0);
        chk("sat_crd", 32'(crd_avail), 32'd0);
        tick();
        chk("sat_stall1", 32'(bus.o_req_ack), 32'd0);
        // Only req1 still waiting; it takes the coincident-credit grant below
        bus.i_req_vld = 2'b10;
        cfg = 1'b1;
        tick();
        cfg = 1'b0;
        tick();
        chk("pend_grant", 32'(bus.o_req_ack), 32'd2);
        bus.i_req_vld = 2'b00;
        n = model(5'b11100, 32'h0, w);
        walk(n, w, 1'b0);
        chk("pend_crd", 32'(crd_avail), 32'd0);

        // Credit return coincident with grant
        cfg = 1'b1;
        tick();
        bus.i_req_vld = 2'b01;
        tick();
        cfg = 1'b0;
        chk("coin_ack", 32'(bus.o_req_ack), 32'd1);
        chk("coin_crd", 32'(crd_avail), 32'd1);
        bus.i_req_vld = 2'b00;
        n = model(5'b10101, 32'h0, w);
        walk(n, w, 1'b0);

        // Invalid code: ack with err, no phases, credit kept
        bus.i_req_vld = 2'b01;
        bus.i_req_code_0 = 5'b10000;
        tick();
        chk("inv_ack", 32'(bus.o_req_ack), 32'd1);
        chk("inv_err", 32'(bus.o_req_err), 32'd1);
        chk("inv_vld", 32'(bus.o_phase_vld), 32'd0);
        chk("inv_crd", 32'(crd_avail), 32'd1);
        bus.i_req_vld = 2'b00;
        tick();
        chk("inv_ack_clr", 32'(bus.o_req_ack), 32'd0);
        chk("inv_err_clr", 32'(bus.o_req_err), 32'd0);
        chk("inv_busy", 32'(busy), 32'd0);

        // Reset during PH2 of a req0 data message
        dval = $urandom;
        bus.i_req_vld = 2'b01;
        bus.i_req_code_0 = 5'b00000;
        bus.i_req_data_0 = dval;
        tick();
        chk("rph_ack", 32'(bus.o_req_ack), 32'd1);
        bus.i_req_vld = 2'b00;
        tick();
        tick();
        chk("rph_ph2", bus.o_phase_data, dval);
        bus.i_count_done = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rph_vld", 32'(bus.o_phase_vld), 32'd0);
        chk("rph_data", bus.o_phase_data, 32'd0);
        chk("rph_busy", 32'(busy), 32'd0);
        chk("rph_crd", 32'(crd_avail), 32'd1);
        #2 rst = 1'b0;
        crd_m = 1;
        pref_m = 1'b0;
        bus.i_req_vld = 2'b11;
        bus.i_req_code_0 = 5'b10101;
        bus.i_req_code_1 = 5'b10111;
        tick();
        chk("rph_restart", 32'(bus.o_req_ack), 32'd1);
        bus.i_req_vld = 2'b10;
        n = model(5'b10101, 32'h0, w);
        walk(n, w, 1'b0);
        crd_m = 0;
        pref_m = 1'b1;
        bus.i_count_done = 1'b0;

        // Randomized traffic against the model
        pend = 2'b10;
        rc[0] = 5'b0;
        rd[0] = 32'h0;
        rc[1] = 5'b10111;
        rd[1] = 32'h0;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 2) != 0 || pend == 2'b00)) begin
                    pend[r] = 1'b1;
                    rc[r] = 5'($urandom_range(0, 31));
                    rd[r] = $urandom;
                end
            end
            bus.i_req_code_0 = rc[0];
            bus.i_req_data_0 = rd[0];
            bus.i_req_code_1 = rc[1];
            bus.i_req_data_1 = rd[1];
            bus.i_req_vld = pend;
            exp_r = (pend == 2'b11) ? pref_m : pend[1];
            if (crd_m == 0) begin
                tick();
                chk("rnd_nocrd", 32'(bus.o_req_ack), 32'd0);
                cfg = 1'b1;
                tick();
                cfg = 1'b0;
                crd_m = 1;
            end
            got = 1'b0;
            for (int k = 0; k < 6 && !got; k++) begin
                tick();
                got = bus.o_req_ack != 2'b00;
            end
            chk("rnd_ack_seen", 32'(got), 32'd1);
            chk("rnd_ack_who", 32'(bus.o_req_ack), exp_r ? 32'd2 : 32'd1);
            n = model(rc[exp_r], rd[exp_r], w);
            chk("rnd_err", 32'(bus.o_req_err), 32'(n == 0));
            pend[exp_r] = 1'b0;
            bus.i_req_vld = pend;
            pref_m = !exp_r;
            if (n != 0) begin
                crd_m--;
                chk("rnd_crd_grant", 32'(crd_avail), 32'(crd_m > 0));
                walk(n, w, 1'b1);
            end else begin
                chk("rnd_err_vld", 32'(bus.o_phase_vld), 32'd0);
                tick();
                chk("rnd_err_clr", 32'(bus.o_req_err), 32'd0);
            end
            chk("rnd_crd_end", 32'(crd_avail), 32'(crd_m > 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
